// File: rtl/clock_period_meter.sv
// clock_period_meter: measures high time, low time and period of a slow clock
// (sig_in) in clk_in cycles. Single-shot or continuous, with a dead-input timeout.
module clock_period_meter #(
    parameter int unsigned CNT_WIDTH = 23,
    parameter int unsigned MAX_COUNT = 2**CNT_WIDTH - 1
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 sig_in,
    input  logic                 start,
    input  logic                 continuous,
    output logic                 busy,
    output logic                 valid,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] high_count,
    output logic [CNT_WIDTH-1:0] low_count,
    output logic [CNT_WIDTH:0]   period
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEAS_HIGH,
        ST_MEAS_LOW
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LP_MAX = CNT_WIDTH'(MAX_COUNT);
    localparam logic [CNT_WIDTH-1:0] LP_ONE = CNT_WIDTH'(1);

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_sig_d;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_at_max;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_tmo_hit;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  r_high_hold;
    logic                  r_valid;
    logic                  r_timeout;
    logic [CNT_WIDTH-1:0]  r_high_count;
    logic [CNT_WIDTH-1:0]  r_low_count;
    logic [CNT_WIDTH:0]    r_period;

    // Two-flop synchronizer plus one history stage; both edges see the same latency.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sig_d <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
            r_sig_d <= r_sync2;
        end
    end

    assign w_rise   = r_sync2 & ~r_sig_d;
    assign w_fall   = ~r_sync2 & r_sig_d;
    assign w_at_max = (r_cnt == LP_MAX);

    // State register.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; an edge seen on the MAX_COUNT cycle beats the timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_ARM;
            end
            ST_ARM: begin
                if (w_rise)        w_next_state = ST_MEAS_HIGH;
                else if (w_at_max) w_next_state = ST_IDLE;
            end
            ST_MEAS_HIGH: begin
                if (w_fall)        w_next_state = ST_MEAS_LOW;
                else if (w_at_max) w_next_state = ST_IDLE;
            end
            ST_MEAS_LOW: begin
                if (w_rise)        w_next_state = continuous ? ST_MEAS_HIGH : ST_IDLE;
                else if (w_at_max) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State-decoded outputs: busy, measurement complete, timeout abort.
    always_comb begin
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_tmo_hit = 1'b0;
        case (r_state)
            ST_ARM: begin
                w_busy    = 1'b1;
                w_tmo_hit = w_at_max & ~w_rise;
            end
            ST_MEAS_HIGH: begin
                w_busy    = 1'b1;
                w_tmo_hit = w_at_max & ~w_fall;
            end
            ST_MEAS_LOW: begin
                w_busy    = 1'b1;
                w_done    = w_rise;
                w_tmo_hit = w_at_max & ~w_rise;
            end
            default: begin
                w_busy    = 1'b0;
            end
        endcase
    end

    // Phase counter, sticky timeout and result registers; the counter saturates at MAX_COUNT.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_cnt        <= '0;
            r_high_hold  <= '0;
            r_valid      <= 1'b0;
            r_timeout    <= 1'b0;
            r_high_count <= '0;
            r_low_count  <= '0;
            r_period     <= '0;
        end else begin
            r_valid <= w_done;
            if (r_state == ST_IDLE && start) begin
                r_timeout <= 1'b0;
            end else if (w_tmo_hit) begin
                r_timeout <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) r_cnt <= '0;
                end
                ST_ARM: begin
                    if (w_rise)         r_cnt <= LP_ONE;
                    else if (!w_at_max) r_cnt <= r_cnt + LP_ONE;
                end
                ST_MEAS_HIGH: begin
                    if (w_fall) begin
                        r_high_hold <= r_cnt;
                        r_cnt       <= LP_ONE;
                    end else if (!w_at_max) begin
                        r_cnt <= r_cnt + LP_ONE;
                    end
                end
                ST_MEAS_LOW: begin
                    if (w_rise) begin
                        r_high_count <= r_high_hold;
                        r_low_count  <= r_cnt;
                        r_period     <= {1'b0, r_high_hold} + {1'b0, r_cnt};
                        r_cnt        <= LP_ONE;
                    end else if (!w_at_max) begin
                        r_cnt <= r_cnt + LP_ONE;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign busy       = w_busy;
    assign valid      = r_valid;
    assign timeout    = r_timeout;
    assign high_count = r_high_count;
    assign low_count  = r_low_count;
    assign period     = r_period;

endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter: randomized and directed stimulus for clock_period_meter,
// checked against a run-length model of the sig_in waveform the bench generates.
`timescale 1ns/1ps
module tb_clock_period_meter;

    localparam int CW   = 8;
    localparam int MAXC = 15;

    logic          clk_in;
    logic          reset;
    logic          sig_in;
    logic          start;
    logic          continuous;
    logic          busy;
    logic          valid;
    logic          timeout;
    logic [CW-1:0] high_count;
    logic [CW-1:0] low_count;
    logic [CW:0]   period;

    clock_period_meter #(
        .CNT_WIDTH(CW),
        .MAX_COUNT(MAXC)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .sig_in    (sig_in),
        .start     (start),
        .continuous(continuous),
        .busy      (busy),
        .valid     (valid),
        .timeout   (timeout),
        .high_count(high_count),
        .low_count (low_count),
        .period    (period)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // per-cycle stimulus entry: sig_in, start, continuous, reset
    typedef struct {bit s; bit st; bit c; bit r;} drv_t;
    typedef struct {int h; int l;} exp_t;
    typedef struct {int h; int l; int p; int t; bit b; bit pb;} obs_t;

    drv_t wave[$];
    exp_t exp_q[$];
    obs_t obs_q[$];
    int   ph_h[$];
    int   ph_l[$];

    int   cyc       = 0;
    bit   prev_busy = 1'b0;

    // collect every valid pulse together with busy now and one cycle earlier
    always @(negedge clk_in) begin
        if (valid === 1'b1)
            obs_q.push_back('{h: int'(high_count), l: int'(low_count), p: int'(period),
                              t: cyc, b: busy, pb: prev_busy});
        prev_busy <= busy;
        cyc       <= cyc + 1;
    end

    task automatic push(input int n, input bit s, input bit st, input bit c, input bit r);
        drv_t d;
        d.s = s; d.st = st; d.c = c; d.r = r;
        for (int i = 0; i < n; i++) wave.push_back(d);
    endtask

    task automatic play();
        foreach (wave[i]) begin
            @(posedge clk_in);
            #1;
            sig_in     = wave[i].s;
            start      = wave[i].st;
            continuous = wave[i].c;
            reset      = wave[i].r;
        end
        wave.delete();
    endtask

    // Build a start pulse followed by the phases in ph_h/ph_l, a closing rise and
    // two extra periods that must be ignored once the meter has stopped.
    task automatic build(input bit cont);
        int r_last;
        r_last = 0;
        exp_q.delete();
        push(1, 1'b0, 1'b1, cont, 1'b0);
        push(3, 1'b0, 1'b0, cont, 1'b0);
        foreach (ph_h[i]) begin
            if (i == ph_h.size() - 1) r_last = wave.size();
            push(ph_h[i], 1'b1, 1'b0, cont, 1'b0);
            push(ph_l[i], 1'b0, 1'b0, cont, 1'b0);
            if (cont || i == 0) exp_q.push_back('{h: ph_h[i], l: ph_l[i]});
        end
        push(4, 1'b1, 1'b0, cont, 1'b0);
        push(3, 1'b0, 1'b0, cont, 1'b0);
        push(2, 1'b1, 1'b0, cont, 1'b0);
        push(6, 1'b0, 1'b0, cont, 1'b0);
        push(8, 1'b0, 1'b0, 1'b0, 1'b0);
        // drop continuous only after the second-to-last result has been taken
        if (cont) for (int k = r_last + 3; k < wave.size(); k++) wave[k].c = 1'b0;
        ph_h.delete();
        ph_l.delete();
    endtask

    task automatic verify(input string nm, input bit cont);
        int n;
        n = (exp_q.size() < obs_q.size()) ? exp_q.size() : obs_q.size();
        check_val($sformatf("%s_nvalid", nm), obs_q.size(), exp_q.size());
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s_high%0d", nm, i), obs_q[i].h, exp_q[i].h);
            check_val($sformatf("%s_low%0d", nm, i), obs_q[i].l, exp_q[i].l);
            check_val($sformatf("%s_period%0d", nm, i), obs_q[i].p, exp_q[i].h + exp_q[i].l);
            check_val($sformatf("%s_busy_before%0d", nm, i), obs_q[i].pb, 1);
            check_val($sformatf("%s_busy_at%0d", nm, i), obs_q[i].b,
                      (cont && i != exp_q.size() - 1) ? 1 : 0);
            if (cont && i > 0)
                check_val($sformatf("%s_spacing%0d", nm, i), obs_q[i].t - obs_q[i-1].t,
                          exp_q[i].h + exp_q[i].l);
        end
        check_val($sformatf("%s_timeout", nm), timeout, 0);
        check_val($sformatf("%s_busy_end", nm), busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        int prev_h;
        int prev_l;
        int hv;
        sig_in     = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        reset      = 1'b1;

        // reset held three cycles with sig_in toggling, then 20 quiet cycles
        for (int i = 0; i < 3; i++) push(1, i[0], 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) push(1, i[1], 1'b0, 1'b0, 1'b0);
        obs_q.delete();
        play();
        check_val("rst_busy", busy, 0);
        check_val("rst_valid_pulses", obs_q.size(), 0);
        check_val("rst_timeout", timeout, 0);
        check_val("rst_high", high_count, 0);
        check_val("rst_low", low_count, 0);
        check_val("rst_period", period, 0);

        // divide-by-4, single shot
        ph_h = '{2, 2}; ph_l = '{2, 2};
        build(1'b0);
        obs_q.delete();
        play();
        verify("div4", 1'b0);

        // 1 high / 2 low, continuous for five results
        for (int i = 0; i < 5; i++) begin ph_h.push_back(1); ph_l.push_back(2); end
        build(1'b1);
        obs_q.delete();
        play();
        verify("odd_cont", 1'b1);

        // random phases in continuous mode, including the 1-cycle and MAX_COUNT boundaries
        for (int i = 0; i < 8; i++) begin
            ph_h.push_back(int'($urandom_range(1, MAXC)));
            ph_l.push_back(int'($urandom_range(1, MAXC)));
        end
        ph_h[2] = MAXC; ph_l[2] = MAXC;
        ph_h[5] = 1;    ph_l[5] = 1;
        build(1'b1);
        prev_h = exp_q[exp_q.size() - 1].h;
        prev_l = exp_q[exp_q.size() - 1].l;
        obs_q.delete();
        play();
        verify("rand_cont", 1'b1);

        // sig_in stuck high: timeout 3 sync cycles + MAX_COUNT counts after the rise
        push(1, 1'b0, 1'b1, 1'b0, 1'b0);
        push(3, 1'b0, 1'b0, 1'b0, 1'b0);
        obs_q.delete();
        play();
        @(posedge clk_in);
        #1;
        sig_in = 1'b1;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk_in);
            #1;
            if (timeout === 1'b1) begin k = i; break; end
        end
        check_val("tmo_latency", k, 3 + MAXC);
        repeat (3) @(posedge clk_in);
        #1;
        check_val("tmo_busy", busy, 0);
        check_val("tmo_valid_pulses", obs_q.size(), 0);
        check_val("tmo_high_kept", high_count, prev_h);
        check_val("tmo_low_kept", low_count, prev_l);
        check_val("tmo_period_kept", period, prev_h + prev_l);

        // a new start clears timeout; with no rise it times out again from ARM
        push(1, 1'b1, 1'b1, 1'b0, 1'b0);
        play();
        @(posedge clk_in);
        #1;
        check_val("restart_timeout_clr", timeout, 0);
        check_val("restart_busy", busy, 1);
        push(25, 1'b1, 1'b0, 1'b0, 1'b0);
        play();
        check_val("arm_timeout", timeout, 1);
        check_val("arm_busy", busy, 0);

        // second start during MEAS_HIGH must be ignored
        ph_h = '{10}; ph_l = '{5};
        build(1'b0);
        wave[9].st = 1'b1;
        obs_q.delete();
        play();
        verify("start_busy", 1'b0);

        // reset during MEAS_LOW discards the measurement
        ph_h = '{4}; ph_l = '{12};
        build(1'b0);
        exp_q.delete();
        wave[14].r = 1'b1;
        wave[15].r = 1'b1;
        obs_q.delete();
        play();
        verify("rst_mid", 1'b0);
        check_val("rst_mid_high", high_count, 0);
        check_val("rst_mid_low", low_count, 0);
        check_val("rst_mid_period", period, 0);

        // asynchronous sig_in, 31 ns high / 40 ns low against a 10 ns clk_in
        push(1, 1'b0, 1'b1, 1'b1, 1'b0);
        push(1, 1'b0, 1'b0, 1'b1, 1'b0);
        obs_q.delete();
        play();
        #3;
        for (int it = 0; it < 8; it++) begin
            if (it == 6) continuous = 1'b0;
            sig_in = 1'b1;
            #31;
            sig_in = 1'b0;
            #40;
        end
        repeat (30) @(posedge clk_in);
        #1;
        check_val("async_nvalid", obs_q.size(), 6);
        foreach (obs_q[i]) begin
            hv = obs_q[i].h;
            check_val($sformatf("async_high_ok%0d", i), (hv == 3 || hv == 4) ? 1 : 0, 1);
            check_val($sformatf("async_period_ok%0d", i),
                      (obs_q[i].p >= 6 && obs_q[i].p <= 8) ? 1 : 0, 1);
            check_val($sformatf("async_sum%0d", i), obs_q[i].p, obs_q[i].h + obs_q[i].l);
        end
        check_val("async_busy_end", busy, 0);
        check_val("async_timeout", timeout, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
